branch_predict_flush: RTL and testbench

BRANCH_PREDICT_FLUSH -- requirements
Module: branch_predict_flush

---
 rtl/branch_predict_flush.sv | 105 ++++++++++
 tb/tb_branch_predict_flush.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_flush.sv
// Bimodal branch predictor (2-bit BHT) with EX-stage misprediction flush/redirect and perf counters.
// Latency: prediction and flush/redirect are combinational; BHT and counters update on the next clk edge; no backpressure.
module branch_predict_flush #(
  parameter int IDX_W      = 6,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16,
  parameter int PREDICT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [2:0]       ex_addr_sel,
  input  logic             ex_less,
  input  logic             ex_zero,
  input  logic             ex_pred_taken,
  output logic             flush_out,
  output logic [1:0]       redirect_sel,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int NUM_ENT = 1 << IDX_W;

  logic [1:0]       bht_q [NUM_ENT];
  logic [1:0]       bht_d [NUM_ENT];
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_cond;
  logic             is_jump;
  logic             actual;
  logic             pred_eff;
  logic             mispred;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0], ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  assign is_cond  = ex_valid && (ex_addr_sel == 3'd1 || ex_addr_sel == 3'd2);
  assign is_jump  = ex_valid && (ex_addr_sel == 3'd3 || ex_addr_sel == 3'd4);
  assign actual   = (ex_addr_sel == 3'd1) ? ex_less : ex_zero;
  assign pred_eff = (PREDICT_EN != 0) ? ex_pred_taken : 1'b0;
  assign mispred  = is_cond && (actual != pred_eff);

  // Lookup reads the registered table, so a same-index update is not visible until next cycle.
  assign if_pred_taken = (PREDICT_EN != 0) ? bht_q[if_idx][1] : 1'b0;

  always_comb begin
    flush_out    = 1'b0;
    redirect_sel = 2'd0;
    if (mispred) begin
      flush_out    = 1'b1;
      redirect_sel = actual ? 2'd1 : 2'd2;
    end else if (is_jump) begin
      flush_out    = 1'b1;
      redirect_sel = 2'd1;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (is_cond) begin
      if (actual && bht_q[ex_idx] != 2'b11) begin
        bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else if (!actual && bht_q[ex_idx] != 2'b00) begin
        bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (is_cond && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispred && !(&mispred_cnt_q)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        bht_q[i] <= 2'b01;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      bht_q         <= bht_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_flush.sv
// Directed bench for branch_predict_flush: default, static (PREDICT_EN=0) and narrow-counter (CNT_W=4) instances share stimulus.
module tb_branch_predict_flush;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_addr_sel;
  logic        ex_less;
  logic        ex_zero;
  logic        ex_pred_taken;

  logic        pred0, flush0;
  logic [1:0]  redir0;
  logic [15:0] bcnt0, mcnt0;
  logic        pred1, flush1;
  logic [1:0]  redir1;
  logic [15:0] bcnt1, mcnt1;
  logic        pred2, flush2;
  logic [1:0]  redir2;
  logic [3:0]  bcnt2, mcnt2;

  int nerr = 0;
  int nchecks = 0;

  branch_predict_flush u_dut0 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pred0),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_addr_sel(ex_addr_sel),
    .ex_less(ex_less), .ex_zero(ex_zero), .ex_pred_taken(ex_pred_taken),
    .flush_out(flush0), .redirect_sel(redir0), .branch_cnt(bcnt0), .mispred_cnt(mcnt0)
  );

  branch_predict_flush #(.PREDICT_EN(0)) u_dut1 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pred1),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_addr_sel(ex_addr_sel),
    .ex_less(ex_less), .ex_zero(ex_zero), .ex_pred_taken(ex_pred_taken),
    .flush_out(flush1), .redirect_sel(redir1), .branch_cnt(bcnt1), .mispred_cnt(mcnt1)
  );

  branch_predict_flush #(.CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pred2),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_addr_sel(ex_addr_sel),
    .ex_less(ex_less), .ex_zero(ex_zero), .ex_pred_taken(ex_pred_taken),
    .flush_out(flush2), .redirect_sel(redir2), .branch_cnt(bcnt2), .mispred_cnt(mcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] pc,
                       input logic less, input logic zero, input logic pt);
    ex_valid      = v;
    ex_addr_sel   = sel;
    ex_pc         = pc;
    ex_less       = less;
    ex_zero       = zero;
    ex_pred_taken = pt;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'h40;
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_pred", 32'(pred0), 32'd0);
    chk("rst_bcnt", 32'(bcnt0), 32'd0);
    chk("rst_mcnt", 32'(mcnt0), 32'd0);
    // Flush logic stays live during reset.
    drive(1'b1, 3'd3, 32'h40, 1'b0, 1'b0, 1'b0);
    chk("rst_jal_flush", 32'(flush0), 32'd1);
    chk("rst_jal_redir", 32'(redir0), 32'd1);
    tick();
    chk("rst_hold_bcnt", 32'(bcnt0), 32'd0);
    rst = 1'b0;

    // beq at 0x40 taken, predicted not-taken: counter 01 -> 10.
    if_pc = 32'h40;
    drive(1'b1, 3'd2, 32'h40, 1'b0, 1'b1, 1'b0);
    chk("beq_flush", 32'(flush0), 32'd1);
    chk("beq_redir", 32'(redir0), 32'd1);
    chk("beq_pred_pre", 32'(pred0), 32'd0);
    tick();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("beq_pred_post", 32'(pred0), 32'd1);
    chk("beq_bcnt", 32'(bcnt0), 32'd1);
    chk("beq_mcnt", 32'(mcnt0), 32'd1);

    // blt at 0x80 taken x3 (predicted taken), then not taken.
    if_pc = 32'h80;
    drive(1'b1, 3'd1, 32'h80, 1'b1, 1'b0, 1'b1);
    chk("blt_ok_flush", 32'(flush0), 32'd0);
    chk("blt_ok_redir", 32'(redir0), 32'd0);
    chk("blt_static_flush", 32'(flush1), 32'd1);
    chk("blt_pred0", 32'(pred0), 32'd0);
    tick();
    chk("blt_pred1", 32'(pred0), 32'd1);
    tick();
    chk("blt_pred2", 32'(pred0), 32'd1);
    tick();
    chk("blt_pred3", 32'(pred0), 32'd1);
    drive(1'b1, 3'd1, 32'h80, 1'b0, 1'b0, 1'b1);
    chk("blt_nt_flush", 32'(flush0), 32'd1);
    chk("blt_nt_redir", 32'(redir0), 32'd2);
    chk("blt_nt_static_flush", 32'(flush1), 32'd0);
    tick();
    chk("blt_nt_pred", 32'(pred0), 32'd1);
    chk("blt_bcnt", 32'(bcnt0), 32'd5);
    chk("blt_mcnt", 32'(mcnt0), 32'd2);
    chk("blt_static_mcnt", 32'(mcnt1), 32'd4);

    // Jumps always redirect and never touch the BHT or counters.
    drive(1'b1, 3'd3, 32'h80, 1'b0, 1'b0, 1'b0);
    chk("jal_flush", 32'(flush0), 32'd1);
    chk("jal_redir", 32'(redir0), 32'd1);
    tick();
    drive(1'b1, 3'd4, 32'h80, 1'b0, 1'b0, 1'b0);
    chk("jalr_flush", 32'(flush0), 32'd1);
    chk("jalr_redir", 32'(redir0), 32'd1);
    tick();
    drive(1'b1, 3'd5, 32'h80, 1'b0, 1'b0, 1'b0);
    chk("sel5_flush", 32'(flush0), 32'd0);
    chk("sel5_redir", 32'(redir0), 32'd0);
    tick();
    drive(1'b0, 3'd2, 32'h80, 1'b0, 1'b0, 1'b1);
    chk("novalid_flush", 32'(flush0), 32'd0);
    tick();
    chk("jmp_bcnt", 32'(bcnt0), 32'd5);
    chk("jmp_mcnt", 32'(mcnt0), 32'd2);
    chk("jmp_bht80", 32'(pred0), 32'd1);
    // 0x80 counter is 10: one not-taken update must drop the prediction.
    drive(1'b1, 3'd1, 32'h80, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bht80_dec", 32'(pred0), 32'd0);

    // Static not-taken: taken beq always flushes, prediction pinned to 0.
    if_pc = 32'h40;
    drive(1'b1, 3'd2, 32'h40, 1'b0, 1'b1, 1'b1);
    chk("static_flush", 32'(flush1), 32'd1);
    chk("static_redir", 32'(redir1), 32'd1);
    chk("static_pred", 32'(pred1), 32'd0);
    chk("dyn_flush", 32'(flush0), 32'd0);
    chk("dyn_pred40", 32'(pred0), 32'd1);
    tick();
    chk("static_pred_post", 32'(pred1), 32'd0);

    // 0x40 now 11; asynchronous reset between edges.
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_pred", 32'(pred0), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_pred", 32'(pred0), 32'd0);
    chk("async_rst_bcnt", 32'(bcnt0), 32'd0);
    chk("async_rst_mcnt", 32'(mcnt0), 32'd0);
    drive(1'b1, 3'd2, 32'h40, 1'b0, 1'b1, 1'b0);
    tick();
    chk("rst_discard_pred", 32'(pred0), 32'd0);
    chk("rst_discard_bcnt", 32'(bcnt0), 32'd0);
    rst = 1'b0;
    tick();
    chk("first_edge_pred", 32'(pred0), 32'd1);
    chk("first_edge_bcnt", 32'(bcnt0), 32'd1);
    chk("first_edge_mcnt", 32'(mcnt0), 32'd1);

    // Narrow counters saturate under 20 mispredicts.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(1'b1, 3'd2, 32'h100, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("sat15_bcnt", 32'(bcnt2), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_bcnt", 32'(bcnt2), 32'd15);
    chk("sat_mcnt", 32'(mcnt2), 32'd15);
    chk("wide_bcnt", 32'(bcnt0), 32'd20);
    chk("wide_mcnt", 32'(mcnt0), 32'd20);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
